// File: rtl/cache_assoc_nvias.sv
// Set-associative, write-back, write-allocate cache with per-set LRU ages.
// One request in flight at a time; misses go through an optional write-back
// of a dirty victim followed by a fill from memory.
module cache_assoc_nvias #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned IDX_W  = 1,
    parameter int unsigned VIAS   = 2,
    parameter int unsigned DATA_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] dado_escrita,
    output logic              resp_valid,
    output logic              hit,
    output logic [DATA_W-1:0] dado_lido,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_dado_escrita,
    input  logic [DATA_W-1:0] mem_dado_lido,
    input  logic              mem_ack
);

    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned SETS  = 1 << IDX_W;
    localparam int unsigned WAY_W = $clog2(VIAS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WAY_W-1:0]  victim_q, victim_d;

    // Registered outputs
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] dado_lido_q, dado_lido_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_endereco_q, mem_endereco_d;
    logic [DATA_W-1:0] mem_dado_escrita_q, mem_dado_escrita_d;

    // Line storage
    logic [VIAS-1:0]   valid_q [SETS];
    logic [VIAS-1:0]   dirty_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][VIAS];
    logic [DATA_W-1:0] data_q  [SETS][VIAS];
    logic [WAY_W-1:0]  age_q   [SETS][VIAS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_in;

    logic              lk_hit;
    logic [WAY_W-1:0]  lk_hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  lk_victim;
    logic              lk_victim_dirty;

    logic              line_we;
    logic [WAY_W-1:0]  line_way;
    logic              line_dirty;
    logic [DATA_W-1:0] line_data;
    logic              lru_we;
    logic [WAY_W-1:0]  lru_acc;
    logic [WAY_W-1:0]  lru_old;

    assign idx    = addr_q[IDX_W-1:0];
    assign tag_in = addr_q[ADDR_W-1:IDX_W];

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign hit              = hit_q;
    assign dado_lido        = dado_lido_q;
    assign mem_req          = mem_req_q;
    assign mem_write        = mem_write_q;
    assign mem_endereco     = mem_endereco_q;
    assign mem_dado_escrita = mem_dado_escrita_q;

    // Tag match, lowest invalid way and oldest way of the indexed set
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        for (int unsigned w = 0; w < VIAS; w++) begin
            if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == tag_in)) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][WAY_W'(w)] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx][WAY_W'(w)] == WAY_W'(VIAS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        lk_victim       = inv_found ? inv_way : lru_way;
        lk_victim_dirty = valid_q[idx][lk_victim] & dirty_q[idx][lk_victim];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lk_hit)               state_d = ST_RESP;
                else if (lk_victim_dirty) state_d = ST_WRITEBACK;
                else                      state_d = ST_FILL;
            end
            ST_WRITEBACK: begin
                if (mem_ack) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (mem_ack) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output, datapath and line-update decode
    always_comb begin
        write_d            = write_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        victim_d           = victim_q;
        req_ready_d        = (state_d == ST_IDLE);
        resp_valid_d       = (state_d == ST_RESP);
        mem_req_d          = (state_d == ST_WRITEBACK) || (state_d == ST_FILL);
        mem_write_d        = (state_d == ST_WRITEBACK);
        hit_d              = hit_q;
        dado_lido_d        = dado_lido_q;
        mem_endereco_d     = mem_endereco_q;
        mem_dado_escrita_d = mem_dado_escrita_q;
        line_we            = 1'b0;
        line_way           = '0;
        line_dirty         = 1'b0;
        line_data          = '0;
        lru_we             = 1'b0;
        lru_acc            = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d = write;
                    addr_d  = endereco;
                    wdata_d = dado_escrita;
                end
            end
            ST_LOOKUP: begin
                victim_d = lk_victim;
                if (lk_hit) begin
                    hit_d   = 1'b1;
                    lru_we  = 1'b1;
                    lru_acc = lk_hit_way;
                    if (write_q) begin
                        line_we     = 1'b1;
                        line_way    = lk_hit_way;
                        line_dirty  = 1'b1;
                        line_data   = wdata_q;
                        dado_lido_d = wdata_q;
                    end else begin
                        dado_lido_d = data_q[idx][lk_hit_way];
                    end
                end else if (lk_victim_dirty) begin
                    mem_endereco_d     = {tag_q[idx][lk_victim], idx};
                    mem_dado_escrita_d = data_q[idx][lk_victim];
                end else begin
                    mem_endereco_d = addr_q;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) mem_endereco_d = addr_q;
            end
            ST_FILL: begin
                if (mem_ack) begin
                    line_we     = 1'b1;
                    line_way    = victim_q;
                    line_dirty  = write_q;
                    line_data   = write_q ? wdata_q : mem_dado_lido;
                    hit_d       = 1'b0;
                    dado_lido_d = write_q ? wdata_q : mem_dado_lido;
                    lru_we      = 1'b1;
                    lru_acc     = victim_q;
                end
            end
            default: ;
        endcase
        lru_old = age_q[idx][lru_acc];
    end

    // Request latch and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q            <= 1'b0;
            addr_q             <= '0;
            wdata_q            <= '0;
            victim_q           <= '0;
            req_ready_q        <= 1'b0;
            resp_valid_q       <= 1'b0;
            hit_q              <= 1'b0;
            dado_lido_q        <= '0;
            mem_req_q          <= 1'b0;
            mem_write_q        <= 1'b0;
            mem_endereco_q     <= '0;
            mem_dado_escrita_q <= '0;
        end else begin
            write_q            <= write_d;
            addr_q             <= addr_d;
            wdata_q            <= wdata_d;
            victim_q           <= victim_d;
            req_ready_q        <= req_ready_d;
            resp_valid_q       <= resp_valid_d;
            hit_q              <= hit_d;
            dado_lido_q        <= dado_lido_d;
            mem_req_q          <= mem_req_d;
            mem_write_q        <= mem_write_d;
            mem_endereco_q     <= mem_endereco_d;
            mem_dado_escrita_q <= mem_dado_escrita_d;
        end
    end

    // Line storage and LRU ages; way w starts with age w
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IDX_W'(s)] <= '0;
                dirty_q[IDX_W'(s)] <= '0;
                for (int unsigned w = 0; w < VIAS; w++) begin
                    tag_q[IDX_W'(s)][WAY_W'(w)]  <= '0;
                    data_q[IDX_W'(s)][WAY_W'(w)] <= '0;
                    age_q[IDX_W'(s)][WAY_W'(w)]  <= WAY_W'(w);
                end
            end
        end else begin
            if (line_we) begin
                valid_q[idx][line_way] <= 1'b1;
                dirty_q[idx][line_way] <= line_dirty;
                tag_q[idx][line_way]   <= tag_in;
                data_q[idx][line_way]  <= line_data;
            end
            if (lru_we) begin
                for (int unsigned w = 0; w < VIAS; w++) begin
                    if (WAY_W'(w) == lru_acc) begin
                        age_q[idx][WAY_W'(w)] <= '0;
                    end else if (age_q[idx][WAY_W'(w)] < lru_old) begin
                        age_q[idx][WAY_W'(w)] <= age_q[idx][WAY_W'(w)] + WAY_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/cache_assoc_nvias.md
CACHE_ASSOC_NVIAS -- requirements
Module: cache_assoc_nvias

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning word address width.
REQ-002 SHALL have parameter IDX_W, default 1, meaning set-index width; sets = 2**IDX_W; TAG_W = ADDR_W-IDX_W.
REQ-003 SHALL have parameter VIAS, default 2, meaning ways per set; legal values 2, 4, 8.
REQ-004 SHALL have parameter DATA_W, default 5, meaning bits per block (one word per block).
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request
- write  in  1  1 = write, 0 = read
- endereco  in  ADDR_W  request address; index = [IDX_W-1:0], tag = upper bits
- dado_escrita  in  DATA_W  write data
- resp_valid  out  1  one-cycle response pulse
- hit  out  1  lookup result of the request being answered
- dado_lido  out  DATA_W  read data (for a write: the written data)
- mem_req  out  1  memory transaction pending
- mem_write  out  1  1 = write-back, 0 = fill
- mem_endereco  out  ADDR_W  memory address
- mem_dado_escrita  out  DATA_W  write-back data
- mem_dado_lido  in  DATA_W  fill data, sampled with mem_ack
- mem_ack  in  1  one-cycle memory completion

Function
REQ-006 SHALL store per line: valid, dirty, tag (TAG_W), data (DATA_W), LRU age (clog2(VIAS) bits).
REQ-007 SHALL use FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESP; req_ready = 1 only in IDLE.
REQ-008 SHALL, in IDLE on req_valid&req_ready, latch write, endereco, dado_escrita and go to LOOKUP.
REQ-009 SHALL, in LOOKUP, declare hit when exactly one valid way of the indexed set has a matching tag; two matching valid ways SHALL NOT arise.
REQ-010 SHALL, on read hit, drive dado_lido from the hit way; on write hit, store dado_escrita and set dirty; then go to RESP.
REQ-011 SHALL choose the miss victim as the lowest-numbered invalid way, else the way whose age equals VIAS-1.
REQ-012 SHALL, on miss with victim valid and dirty, enter WRITEBACK: mem_req=1, mem_write=1, mem_endereco={victim tag, index}, mem_dado_escrita=victim data; on mem_ack go to FILL.
REQ-013 SHALL, on miss with victim invalid or clean, go straight to FILL (no memory write).
REQ-014 SHALL, in FILL, drive mem_req=1, mem_write=0, mem_endereco=latched address; on mem_ack write mem_dado_lido, tag, valid=1, dirty=0 to the victim; for a write request overwrite data with dado_escrita and set dirty=1 (write-allocate); go to RESP.
REQ-015 SHALL hold mem_req, mem_write, mem_endereco, mem_dado_escrita stable until mem_ack; mem_ack is ignored when mem_req=0; mem_ack in the first cycle of mem_req is legal.
REQ-016 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; hit and dado_lido SHALL hold their values until the next RESP.
REQ-017 SHALL give a hit latency of exactly 2 cycles: acceptance edge -> LOOKUP -> resp_valid high the following cycle.
REQ-018 SHALL update LRU on every completed access: accessed way age 0; each other way of the set with age below the accessed way's old age increments; others unchanged; ages in a set stay a permutation of 0..VIAS-1.
REQ-019 SHALL ignore req_valid outside IDLE (no queueing).

Reset
REQ-020 SHALL, on reset high, immediately: state IDLE, all valid=0, all dirty=0, age of way w = w in every set, req_ready=0 while reset is high, resp_valid=0, hit=0, dado_lido=0, mem_req=0, mem_write=0, mem_endereco=0, mem_dado_escrita=0.
REQ-021 SHALL abandon any in-flight memory transaction on reset; no line is updated by a mem_ack arriving during or after reset.

Verification (VIAS=2, IDX_W=1, ADDR_W=5, DATA_W=5 unless stated)
REQ-022 Cold read 5'b00010 -> FILL read at 00010; mem_dado_lido=7 -> resp hit=0 dado_lido=7; repeat read -> hit=1 dado_lido=7 two cycles after acceptance, mem_req stays 0.
REQ-023 Write 00010 data 9 (hit), read 00100 (miss, fills way1), read 00110 -> WRITEBACK addr 00010 data 9 first, then FILL 00110.
REQ-024 Read 00010, read 00100, read 00110 (all clean) -> no mem_write=1 cycle; 00010 evicted; reading 00010 misses again.
REQ-025 mem_ack delayed 5 cycles during FILL -> mem_req/mem_endereco stable all 5 cycles, req_ready=0, req_valid pulses ignored.
REQ-026 reset asserted mid-FILL -> mem_req=0 the same cycle; after release, read of the same address misses.
REQ-027 VIAS=4: reads of tags 0,1,2,3 to set 0, re-read tag 0, read tag 4 -> tag 1 evicted.
